// File: rtl/logic_unit_pipe_if.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the operation request, result and status signals of
// logic_unit_pipe. clk and rst_n are not part of the bundle.
//
//   in_valid/in_ready   request handshake (upstream -> block)
//   a, b, op            operands and function select
//   acc_en, acc_clr     accumulator controls
//   out_valid/out_ready result handshake (block -> downstream)
//   y, zero, parity     registered result and flags
//   op_count            saturating count of result handshakes
//
// Modports:
//   master : the side that issues operations and consumes results
//   slave  : the logic unit itself
// ---------------------------------------------------------------------------
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity, op_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Registered WIDTH-bit bitwise logic unit with one result stage, zero and
// parity flags, an internal accumulator for chained reductions and a
// saturating count of delivered results.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : logic_unit_pipe_if.slave (operation request, result, flags,
//            op_count)
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are 1. Once out_valid is raised, y/zero/parity stay
// stable until the result is taken. in_ready depends only on the output
// register state and out_ready, never on in_valid.
//
// Opcodes: 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B),
//          100 ~(A|B), 101 ~(A^B), 110 ~A, 111 B
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_pipe_if.slave  bus
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_result;

    // The single result register can take a new word when empty or when
    // its current word leaves on this same edge.
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    // A clear arriving with an accumulate operation is applied first, so
    // the operation sees an accumulator of zero.
    assign w_acc_eff = bus.acc_clr ? '0 : r_acc;
    assign w_opa     = bus.acc_en ? w_acc_eff : bus.a;

    always_comb begin
        w_result = '0;
        case (bus.op)
            3'b000:  w_result = w_opa & bus.b;
            3'b001:  w_result = w_opa | bus.b;
            3'b010:  w_result = w_opa ^ bus.b;
            3'b011:  w_result = ~(w_opa & bus.b);
            3'b100:  w_result = ~(w_opa | bus.b);
            3'b101:  w_result = ~(w_opa ^ bus.b);
            3'b110:  w_result = ~w_opa;
            default: w_result = bus.b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_y         <= w_result;
                r_zero      <= (w_result == '0);
                r_parity    <= ^w_result;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_xfer && bus.acc_en) begin
                r_acc <= w_result;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end

            // Saturate at all-ones rather than wrapping.
            if (w_out_xfer && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;
    assign bus.op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed scenarios followed by randomized traffic. A reference model,
// evaluated at each rising edge, decides which operations are accepted and
// pushes their expected {y, zero, parity} into exp_q; a monitor on the
// falling edge compares whatever the DUT presents. A second instance with a
// 3-bit counter shares the same stimulus so counter saturation is reached.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int CW_S  = 3;

    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW))   bus ();
    logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW_S)) bus_s ();

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW_S)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.a         = bus.a;
    assign bus_s.b         = bus.b;
    assign bus_s.op        = bus.op;
    assign bus_s.acc_en    = bus.acc_en;
    assign bus_s.acc_clr   = bus.acc_clr;
    assign bus_s.out_ready = bus.out_ready;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_f(input logic [2:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] z);
        logic [3:0] tt;
        logic [W-1:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1010;
        endcase
        for (int i = 0; i < W; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    function automatic logic [W+1:0] pack_exp(input logic [W-1:0] r);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(r[i]);
        return {r, (ones == 0), (ones % 2 == 1)};
    endfunction

    logic [W+1:0] exp_q[$];
    bit           m_valid = 1'b0;
    logic [W-1:0] m_acc   = '0;
    int           m_count = 0;

    always @(posedge clk) begin
        bit           xin;
        bit           xout;
        logic [W-1:0] opa;
        logic [W-1:0] res;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_acc   = '0;
            m_count = 0;
            exp_q.delete();
        end else begin
            xin  = bus.in_valid && (!m_valid || bus.out_ready);
            xout = m_valid && bus.out_ready;
            if (xout && m_count < 65535) m_count++;
            opa = bus.acc_en ? (bus.acc_clr ? '0 : m_acc) : bus.a;
            res = ref_f(bus.op, opa, bus.b);
            if (xin) exp_q.push_back(pack_exp(res));
            if (xin) m_valid = 1'b1;
            else if (xout) m_valid = 1'b0;
            if (xin && bus.acc_en) m_acc = res;
            else if (bus.acc_clr) m_acc = '0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (mon_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
            chk("op_count", 64'(bus.op_count), 64'(m_count));
            chk("op_count_sat", 64'(bus_s.op_count), 64'((m_count > 7) ? 7 : m_count));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("y", 64'(bus.y), 64'(e[W+1:2]));
                    chk("zero", 64'(bus.zero), 64'(e[1]));
                    chk("parity", 64'(bus.parity), 64'(e[0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic en, input logic clr);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One operation with out_ready=1: check the result, then let it drain.
    task automatic issue_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic en, input logic clr,
                               input logic [W-1:0] ey, input logic ez, input logic ep);
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, op, en, clr);
        tick();
        idle();
        @(negedge clk);
        chk({name, "_y"}, 64'(bus.y), 64'(ey));
        chk({name, "_zero"}, 64'(bus.zero), 64'(ez));
        chk({name, "_parity"}, 64'(bus.parity), 64'(ep));
        tick();
    endtask

    logic [W-1:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'h0F};

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        reset_dut();
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_y", 64'(bus.y), 64'(0));
        chk("rst_zero", 64'(bus.zero), 64'(0));
        chk("rst_parity", 64'(bus.parity), 64'(0));
        chk("rst_op_count", 64'(bus.op_count), 64'(0));
        mon_en = 1'b1;

        // 1: AND
        drive(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("and_valid", 64'(bus.out_valid), 64'(1));
        chk("and_y", 64'(bus.y), 64'(8'h30));
        chk("and_zero", 64'(bus.zero), 64'(0));
        chk("and_parity", 64'(bus.parity), 64'(0));
        tick();
        @(negedge clk);
        chk("and_drained", 64'(bus.out_valid), 64'(0));
        chk("and_count", 64'(bus.op_count), 64'(1));

        // 2: op sweep back-to-back
        tick();
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b0, 1'b0);
            tick();
            @(negedge clk);
            chk("sweep_y", 64'(bus.y), 64'(sweep_exp[i]));
            chk("sweep_in_ready", 64'(bus.in_ready), 64'(1));
        end
        idle();
        tick();
        @(negedge clk);
        chk("sweep_count", 64'(bus.op_count), 64'(8));
        tick();

        // 3: zero flag
        issue_check("xor_zero", 8'hAA, 8'hAA, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        issue_check("nor_ff", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        // 4: accumulate chain, first step clears before use
        issue_check("acc1", 8'hFF, 8'h01, 3'd1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
        issue_check("acc2", 8'hFF, 8'h02, 3'd1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
        issue_check("acc3", 8'hFF, 8'h04, 3'd1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1);

        // 5: backpressure
        drive(1'b1, 8'h0F, 8'hFF, 3'd0, 1'b0, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h33, 8'h0F, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_y_hold", 64'(bus.y), 64'(8'h0F));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("bp_second_y", 64'(bus.y), 64'(8'h3F));
        tick();

        // 6: reset with a result pending and a new request present
        drive(1'b1, 8'h00, 8'hC3, 3'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h11, 8'h22, 3'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_y", 64'(bus.y), 64'(0));
        chk("mid_rst_count", 64'(bus.op_count), 64'(0));
        issue_check("post_rst_acc", 8'hEE, 8'h10, 3'd1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's single-bit 2-input gate.
- Computes one of eight bitwise logic functions on WIDTH-bit operands, selected at run time by an opcode.
- Results are registered behind a valid/ready handshake, with zero/parity flags and an optional accumulate mode for chained reductions.
- Sits in the CPU datapath as the logic half of the execute stage, beside the adder.

Parameters:
- WIDTH, 8: operand and result width in bits (legal range 1..64).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A (ignored when acc_en=1).
- b  input  WIDTH  operand B.
- op  input  3  function select (encoding below).
- acc_en  input  1  use the accumulator as operand A and write the result back to it.
- acc_clr  input  1  clear the accumulator.
- out_valid  output  1  y/zero/parity hold a result.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  registered result.
- zero  output  1  registered: y == 0.
- parity  output  1  registered: XOR-reduction of y (1 = odd number of ones).
- op_count  output  CNT_W  number of output handshakes since reset, saturating.

Behaviour:
- Opcode encoding, all bitwise:
  - 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B)
  - 100 ~(A|B), 101 ~(A^B), 110 ~A, 111 B
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, y=0, zero=0, parity=0, op_count=0, accumulator=0.
  - Reset overrides every other input, including a transfer in the same cycle.
  - An in-flight result is discarded.
- in_ready = ~out_valid | out_ready. This is combinational; no combinational path from in_valid to in_ready.
- Input transfer: occurs when in_valid & in_ready at a rising edge.
  - On the next edge after the transfer: out_valid=1, y = f(op, A, B), zero and parity computed from that same y.
  - Latency is 1 cycle. Full throughput is one operation per cycle when out_ready is held at 1.
- Output transfer: occurs when out_valid & out_ready.
  - If there is no simultaneous input transfer, out_valid clears to 0.
  - If there is a simultaneous input transfer, out_valid stays 1 and the new result loads.
- Backpressure: while out_valid=1 and out_ready=0, y/zero/parity/out_valid hold stable and in_ready=0.
- Accumulator (WIDTH bits, internal):
  - On a transfer with acc_en=1: A := accumulator (port a ignored), and the accumulator is loaded with the new result.
  - On a transfer with acc_en=0: the accumulator is unchanged.
  - acc_clr=1 takes effect with or without a transfer; the accumulator becomes 0 at that edge.
  - acc_clr=1 together with a transfer and acc_en=1: A := 0 for that operation, then the accumulator := result. Clear is applied before use.
  - acc_clr=1 together with a transfer and acc_en=0: the accumulator := 0 and the result uses port a.
- op_count:
  - Increments by 1 on every output transfer.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by reset.
- Inputs are sampled only on a transfer. Values of a, b, op and acc_en in non-transfer cycles are don't-care.

Test Plan (WIDTH=8, CNT_W=16):
1. Reset then AND: a=0xF0, b=0x3C, op=000, out_ready=1 → next cycle y=0x30, zero=0, parity=0, out_valid=1; following cycle out_valid=0 and op_count=1.
2. Op sweep: a=0xA5, b=0x0F, ops 000..111 back-to-back with out_ready=1 → y = 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0x5A, 0x0F on consecutive cycles; in_ready stays 1; op_count=8.
3. Zero flag: XOR with a=0xAA, b=0xAA → y=0x00, zero=1, parity=0. Then NOR with a=0x00, b=0x00 → y=0xFF, zero=0, parity=0.
4. Accumulate: acc_clr=1 with acc_en=1, op=001, b=0x01; then acc_en=1, op=001, b=0x02; then b=0x04 → y=0x01, 0x03, 0x07 with parity=1, 0, 1.
5. Backpressure: out_ready=0 after the first result (a=0x0F, b=0xFF, op=000) → y=0x0F held 3 cycles, in_ready=0, a second input is not accepted. Raise out_ready → y changes to the second result one cycle later.
6. Reset mid-operation: rst_n=0 on a cycle with out_valid=1 and in_valid=1 → next cycle out_valid=0, y=0, op_count=0, accumulator=0. An acc_en operation after reset with op=001, b=0x10 yields y=0x10.
